// File: rtl/yari_mem_arbiter_pkg.sv
// Shared constants for the core memory-port arbiter: transaction tags, limits and owner encoding.
// The caches use the same ID_DC/ID_IC tags.
package yari_mem_arbiter_pkg;

    localparam int STARVE_LIMIT    = 8;
    localparam int MAX_OUTSTANDING = 4;
    localparam int CNT_W           = 3;
    localparam int ID_W            = 2;
    // The starve counter must reach STARVE_LIMIT itself, which needs one more bit than CNT_W.
    localparam int STARVE_W        = $clog2(STARVE_LIMIT + 1);

    localparam logic [ID_W-1:0] ID_DC = 2'd1;
    localparam logic [ID_W-1:0] ID_IC = 2'd2;

    typedef enum logic {
        OWNER_D = 1'b0,
        OWNER_I = 1'b1
    } owner_t;

endpackage

// File: rtl/yari_mem_arb_ctr.sv
// Saturating up/down counter of in-flight reads for one requester.
// Flags full at MAX and underflow when a return arrives with nothing outstanding.
module yari_mem_arb_ctr
    import yari_mem_arbiter_pkg::*;
#(
    parameter int W   = CNT_W,
    parameter int MAX = MAX_OUTSTANDING
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         full,
    output logic         underflow
);

    localparam logic [W-1:0] MAX_C = W'(MAX);

    assign full      = (count >= MAX_C);
    assign underflow = dec & (count == '0);

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc & ~dec & ~full) begin
            count <= count + 1'b1;
        end else if (dec & ~inc & (count != '0)) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/yari_mem_arbiter.sv
// Shares the core memory port between dmem and imem with combinational grant, a stall lock,
// imem anti-starvation and per-requester outstanding-read limits with tag-based return routing.
module yari_mem_arbiter
    import yari_mem_arbiter_pkg::*;
(
    input  logic        clock,
    input  logic        rst,

    output logic        dmem_waitrequest,
    input  logic [29:0] dmem_address,
    input  logic        dmem_read,
    input  logic        dmem_write,
    input  logic [31:0] dmem_writedata,
    input  logic [3:0]  dmem_writedatamask,
    output logic [31:0] dmem_readdata,
    output logic        dmem_readdatavalid,

    output logic        imem_waitrequest,
    input  logic [29:0] imem_address,
    input  logic        imem_read,
    output logic [31:0] imem_readdata,
    output logic        imem_readdatavalid,

    input  logic        mem_waitrequest,
    output logic [1:0]  mem_id,
    output logic [29:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_writedatamask,
    input  logic [31:0] mem_readdata,
    input  logic [1:0]  mem_readdataid,

    output logic        proto_err
);

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic                lock;
    owner_t              lock_owner;
    logic [STARVE_W-1:0] starve;

    logic [CNT_W-1:0] out_d, out_i;
    logic full_d, full_i, unf_d, unf_i;
    logic d_elig, i_elig, gnt_d, gnt_i;
    logic d_strobe, g_strobe;
    logic acc_i, rd_acc_d, rd_acc_i;
    logic ret_d, ret_i;

    assign d_strobe = dmem_read | dmem_write;
    assign d_elig   = dmem_write | (dmem_read & ~full_d);
    assign i_elig   = imem_read & ~full_i;

    always_comb begin
        gnt_d = 1'b0;
        gnt_i = 1'b0;
        if (lock) begin
            gnt_d = (lock_owner == OWNER_D);
            gnt_i = (lock_owner == OWNER_I);
        end else if (d_elig & i_elig) begin
            if (starve == STARVE_MAX) gnt_i = 1'b1;
            else                      gnt_d = 1'b1;
        end else begin
            gnt_d = d_elig;
            gnt_i = i_elig;
        end
    end

    assign mem_id            = gnt_d ? ID_DC : ID_IC;
    assign mem_address       = gnt_d ? dmem_address : imem_address;
    assign mem_read          = (gnt_d & dmem_read) | (gnt_i & imem_read);
    assign mem_write         = gnt_d & dmem_write;
    assign mem_writedata     = dmem_writedata;
    assign mem_writedatamask = dmem_writedatamask;

    assign dmem_waitrequest  = gnt_d ? mem_waitrequest : 1'b1;
    assign imem_waitrequest  = gnt_i ? mem_waitrequest : 1'b1;

    assign g_strobe = (gnt_d & d_strobe) | (gnt_i & imem_read);
    assign acc_i    = gnt_i & imem_read & ~mem_waitrequest;
    assign rd_acc_d = gnt_d & dmem_read & ~mem_waitrequest;
    assign rd_acc_i = acc_i;

    assign ret_d              = (mem_readdataid == ID_DC);
    assign ret_i              = (mem_readdataid == ID_IC);
    assign dmem_readdatavalid = ret_d;
    assign imem_readdatavalid = ret_i;
    assign dmem_readdata      = mem_readdata;
    assign imem_readdata      = mem_readdata;

    // A stalled granted strobe keeps the lock; accept or a dropped strobe releases it.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            lock       <= 1'b0;
            lock_owner <= OWNER_D;
            starve     <= '0;
            proto_err  <= 1'b0;
        end else begin
            lock <= g_strobe & mem_waitrequest;
            if (g_strobe & mem_waitrequest) lock_owner <= gnt_i ? OWNER_I : OWNER_D;
            if (~imem_read | acc_i)        starve <= '0;
            else if (starve != STARVE_MAX) starve <= starve + 1'b1;
            if (unf_d | unf_i) proto_err <= 1'b1;
        end
    end

    yari_mem_arb_ctr u_ctr_d (
        .clock     (clock),
        .rst       (rst),
        .inc       (rd_acc_d),
        .dec       (ret_d),
        .count     (out_d),
        .full      (full_d),
        .underflow (unf_d)
    );

    yari_mem_arb_ctr u_ctr_i (
        .clock     (clock),
        .rst       (rst),
        .inc       (rd_acc_i),
        .dec       (ret_i),
        .count     (out_i),
        .full      (full_i),
        .underflow (unf_i)
    );

endmodule

// File: tb/tb_yari_mem_arbiter.sv
// Directed bench for yari_mem_arbiter: a vector table for single-cycle grant/mux/routing
// behaviour, then hand sequences for starvation, lock, outstanding limit, underflow and reset.
module tb_yari_mem_arbiter;

    logic        clock = 1'b0;
    logic        rst = 1'b0;
    logic        dmem_waitrequest;
    logic [29:0] dmem_address = '0;
    logic        dmem_read = 1'b0;
    logic        dmem_write = 1'b0;
    logic [31:0] dmem_writedata = '0;
    logic [3:0]  dmem_writedatamask = '0;
    logic [31:0] dmem_readdata;
    logic        dmem_readdatavalid;
    logic        imem_waitrequest;
    logic [29:0] imem_address = '0;
    logic        imem_read = 1'b0;
    logic [31:0] imem_readdata;
    logic        imem_readdatavalid;
    logic        mem_waitrequest = 1'b0;
    logic [1:0]  mem_id;
    logic [29:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_writedatamask;
    logic [31:0] mem_readdata = '0;
    logic [1:0]  mem_readdataid;
    logic        proto_err;

    logic        auto_ret = 1'b0;
    logic [1:0]  rid_man = 2'd0;
    logic [1:0]  ret_q = 2'd0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    // Memory model: one-cycle read latency, returns the tag of the read accepted last cycle.
    always @(posedge clock) ret_q <= (mem_read && !mem_waitrequest) ? mem_id : 2'd0;
    assign mem_readdataid = auto_ret ? ret_q : rid_man;

    yari_mem_arbiter dut (
        .clock              (clock),
        .rst                (rst),
        .dmem_waitrequest   (dmem_waitrequest),
        .dmem_address       (dmem_address),
        .dmem_read          (dmem_read),
        .dmem_write         (dmem_write),
        .dmem_writedata     (dmem_writedata),
        .dmem_writedatamask (dmem_writedatamask),
        .dmem_readdata      (dmem_readdata),
        .dmem_readdatavalid (dmem_readdatavalid),
        .imem_waitrequest   (imem_waitrequest),
        .imem_address       (imem_address),
        .imem_read          (imem_read),
        .imem_readdata      (imem_readdata),
        .imem_readdatavalid (imem_readdatavalid),
        .mem_waitrequest    (mem_waitrequest),
        .mem_id             (mem_id),
        .mem_address        (mem_address),
        .mem_read           (mem_read),
        .mem_write          (mem_write),
        .mem_writedata      (mem_writedata),
        .mem_writedatamask  (mem_writedatamask),
        .mem_readdata       (mem_readdata),
        .mem_readdataid     (mem_readdataid),
        .proto_err          (proto_err)
    );

    typedef struct {
        logic       dr, dw, ir, mwr;
        logic [1:0] rid;
        logic       e_dwr, e_iwr, e_rd, e_wr;
        logic [1:0] e_id;
        logic       e_asel_d;
        logic       e_dv, e_iv;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
    endtask

    task automatic idle_inputs();
        dmem_read = 1'b0; dmem_write = 1'b0; imem_read = 1'b0;
        mem_waitrequest = 1'b0; rid_man = 2'd0; auto_ret = 1'b0;
    endtask

    initial begin
        //               dr dw ir mwr rid  dwr iwr rd wr id  asel dv iv
        vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,2'd0, 1'b1,1'b1,1'b0,1'b0,2'd2,1'b0,1'b0,1'b0};
        vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,2'd0, 1'b0,1'b1,1'b1,1'b0,2'd1,1'b1,1'b0,1'b0};
        vecs[2]  = '{1'b0,1'b0,1'b1,1'b0,2'd0, 1'b1,1'b0,1'b1,1'b0,2'd2,1'b0,1'b0,1'b0};
        vecs[3]  = '{1'b1,1'b0,1'b1,1'b0,2'd0, 1'b0,1'b1,1'b1,1'b0,2'd1,1'b1,1'b0,1'b0};
        vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,2'd0, 1'b0,1'b1,1'b0,1'b1,2'd1,1'b1,1'b0,1'b0};
        vecs[5]  = '{1'b0,1'b1,1'b1,1'b0,2'd0, 1'b0,1'b1,1'b0,1'b1,2'd1,1'b1,1'b0,1'b0};
        vecs[6]  = '{1'b1,1'b0,1'b0,1'b1,2'd0, 1'b1,1'b1,1'b1,1'b0,2'd1,1'b1,1'b0,1'b0};
        vecs[7]  = '{1'b0,1'b0,1'b1,1'b1,2'd0, 1'b1,1'b1,1'b1,1'b0,2'd2,1'b0,1'b0,1'b0};
        vecs[8]  = '{1'b0,1'b0,1'b0,1'b0,2'd1, 1'b1,1'b1,1'b0,1'b0,2'd2,1'b0,1'b1,1'b0};
        vecs[9]  = '{1'b0,1'b0,1'b0,1'b0,2'd2, 1'b1,1'b1,1'b0,1'b0,2'd2,1'b0,1'b0,1'b1};
        vecs[10] = '{1'b0,1'b0,1'b0,1'b0,2'd3, 1'b1,1'b1,1'b0,1'b0,2'd2,1'b0,1'b0,1'b0};

        dmem_address = 30'h111; imem_address = 30'h222;
        #2;
        chk("reset_proto_err", 32'(proto_err), 32'd0);
        chk("reset_mem_id", 32'(mem_id), 32'd2);
        rst = 1'b1;
        tick();

        // Single-cycle vectors, each from a freshly reset state.
        for (int k = 0; k < 11; k++) begin
            do_reset();
            dmem_read = vecs[k].dr; dmem_write = vecs[k].dw; imem_read = vecs[k].ir;
            mem_waitrequest = vecs[k].mwr; rid_man = vecs[k].rid;
            mem_readdata = 32'hCAFE_0000 + 32'(k);
            dmem_writedata = 32'h5A5A_0000 + 32'(k); dmem_writedatamask = 4'(k);
            #1;
            chk($sformatf("v%0d_dwait", k), 32'(dmem_waitrequest), 32'(vecs[k].e_dwr));
            chk($sformatf("v%0d_iwait", k), 32'(imem_waitrequest), 32'(vecs[k].e_iwr));
            chk($sformatf("v%0d_read", k), 32'(mem_read), 32'(vecs[k].e_rd));
            chk($sformatf("v%0d_write", k), 32'(mem_write), 32'(vecs[k].e_wr));
            chk($sformatf("v%0d_id", k), 32'(mem_id), 32'(vecs[k].e_id));
            chk($sformatf("v%0d_addr", k), 32'(mem_address),
                vecs[k].e_asel_d ? 32'h111 : 32'h222);
            chk($sformatf("v%0d_dvalid", k), 32'(dmem_readdatavalid), 32'(vecs[k].e_dv));
            chk($sformatf("v%0d_ivalid", k), 32'(imem_readdatavalid), 32'(vecs[k].e_iv));
            chk($sformatf("v%0d_drdata", k), dmem_readdata, 32'hCAFE_0000 + 32'(k));
            chk($sformatf("v%0d_irdata", k), imem_readdata, 32'hCAFE_0000 + 32'(k));
            chk($sformatf("v%0d_wdata", k), mem_writedata, 32'h5A5A_0000 + 32'(k));
            chk($sformatf("v%0d_wmask", k), 32'(mem_writedatamask), 32'(k[3:0]));
            tick();
        end

        // Anti-starvation: 8 dmem accepts then 1 imem accept, repeating.
        idle_inputs(); do_reset();
        auto_ret = 1'b1; dmem_read = 1'b1; imem_read = 1'b1;
        for (int k = 0; k < 20; k++) begin
            #2;
            chk($sformatf("starve_c%0d_dwait", k), 32'(dmem_waitrequest), (k % 9 == 8) ? 32'd1 : 32'd0);
            chk($sformatf("starve_c%0d_iwait", k), 32'(imem_waitrequest), (k % 9 == 8) ? 32'd0 : 32'd1);
            chk($sformatf("starve_c%0d_le8", k), 32'(dut.starve <= 4'd8), 32'd1);
            tick();
        end

        // dmem lock: stalled dmem keeps the port while imem arrives.
        idle_inputs(); do_reset();
        dmem_address = 30'h100; dmem_read = 1'b1; mem_waitrequest = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) imem_read = 1'b1;
            if (k == 3) mem_waitrequest = 1'b0;
            #2;
            chk($sformatf("dlock_c%0d_addr", k), 32'(mem_address), 32'h100);
            chk($sformatf("dlock_c%0d_id", k), 32'(mem_id), 32'd1);
            chk($sformatf("dlock_c%0d_iwait", k), 32'(imem_waitrequest), 32'd1);
            chk($sformatf("dlock_c%0d_dwait", k), 32'(dmem_waitrequest), (k == 3) ? 32'd0 : 32'd1);
            tick();
        end
        dmem_read = 1'b0;
        #2;
        chk("dlock_after_iwait", 32'(imem_waitrequest), 32'd0);
        chk("dlock_after_id", 32'(mem_id), 32'd2);
        chk("dlock_after_read", 32'(mem_read), 32'd1);
        tick();

        // imem lock: stalled imem keeps the port when dmem arrives.
        idle_inputs(); do_reset();
        dmem_address = 30'h111; imem_read = 1'b1; mem_waitrequest = 1'b1;
        #2; tick();
        dmem_read = 1'b1;
        #2;
        chk("ilock_id", 32'(mem_id), 32'd2);
        chk("ilock_addr", 32'(mem_address), 32'h222);
        chk("ilock_dwait", 32'(dmem_waitrequest), 32'd1);
        tick();
        mem_waitrequest = 1'b0;
        #2;
        chk("ilock_accept", 32'(imem_waitrequest), 32'd0);
        tick();
        imem_read = 1'b0;
        #2;
        chk("ilock_release_id", 32'(mem_id), 32'd1);
        tick();

        // Outstanding limit on imem.
        idle_inputs(); do_reset();
        imem_read = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #2;
            chk($sformatf("lim_acc%0d", k), 32'(imem_waitrequest), 32'd0);
            tick();
        end
        #2;
        chk("lim_5th_wait", 32'(imem_waitrequest), 32'd1);
        chk("lim_5th_read", 32'(mem_read), 32'd0);
        tick();
        rid_man = 2'd2;
        #2;
        chk("lim_ret_still_wait", 32'(imem_waitrequest), 32'd1);
        tick();
        rid_man = 2'd0;
        #2;
        chk("lim_unblock_wait", 32'(imem_waitrequest), 32'd0);
        chk("lim_unblock_read", 32'(mem_read), 32'd1);
        tick();

        // Accept and return in the same cycle leave out_d unchanged.
        idle_inputs(); do_reset();
        dmem_read = 1'b1;
        #2; tick();
        rid_man = 2'd1;
        #2;
        chk("same_dvalid", 32'(dmem_readdatavalid), 32'd1);
        chk("same_dwait", 32'(dmem_waitrequest), 32'd0);
        tick();
        dmem_read = 1'b0;
        tick();
        rid_man = 2'd0;
        #2;
        chk("same_one_left", 32'(proto_err), 32'd0);
        rid_man = 2'd1;
        tick();
        rid_man = 2'd0;
        #2;
        chk("same_underflow", 32'(proto_err), 32'd1);
        tick();

        // Sticky proto_err, then async reset with reads in flight.
        idle_inputs(); do_reset();
        rid_man = 2'd2;
        tick();
        rid_man = 2'd0;
        #2;
        chk("perr_set", 32'(proto_err), 32'd1);
        tick(); tick(); tick();
        chk("perr_sticky", 32'(proto_err), 32'd1);
        dmem_read = 1'b1;
        tick(); tick();
        dmem_read = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_perr", 32'(proto_err), 32'd0);
        chk("rst_async_id", 32'(mem_id), 32'd2);
        rst = 1'b1;
        dmem_write = 1'b1;
        #1;
        chk("rst_after_write", 32'(mem_write), 32'd1);
        chk("rst_after_dwait", 32'(dmem_waitrequest), 32'd0);
        chk("rst_after_id", 32'(mem_id), 32'd1);
        tick();
        dmem_write = 1'b0; rid_man = 2'd1;
        tick();
        rid_man = 2'd0;
        #2;
        chk("rst_forgot_reads", 32'(proto_err), 32'd1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
